hazard: RTL and testbench

HAZARD -- requirements
Module: hazard

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_cnt.sv | 15 +
 rtl/hazard.sv | 51 +++++
 tb/tb_hazard.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared widths and helpers for the hazard unit and its statistics counters.
package hazard_pkg;
    localparam int REG_W = 4;
    localparam int CNT_W = 16;

    // Counts up by one and holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return &cnt ? cnt : cnt + 1'b1;
    endfunction
endpackage

// File: rtl/hazard_cnt.sv
// hazard_cnt: saturating event counter, built only when HAZARD_STATS_EN is defined.
`ifdef HAZARD_STATS_EN
module hazard_cnt
    import hazard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    always_ff @(posedge clk_i)
        if (rst_i) cnt_o <= '0;
        else if (inc_i) cnt_o <= sat_inc(cnt_o);
endmodule
`endif

// File: rtl/hazard.sv
// hazard: load-use stall, JR and branch-misprediction hazard detection.
// HAZARD_STATS_EN adds four saturating event counters.
module hazard
    import hazard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             memtoreg_i,
    input  logic             memread_i,
    input  logic [REG_W-1:0] regdst_i,
    input  logic [REG_W-1:0] regsrc1_i,
    input  logic [REG_W-1:0] regsrc2_i,
    input  logic             isjump_i,
    input  logic             ifbranch_i,
    input  logic             prediction_i,
    output logic             stall_LW_o,
    output logic             jr_o,
    output logic             prewrong_o,
    output logic             precorrc_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] jr_cnt_o,
    output logic [CNT_W-1:0] wrong_cnt_o,
    output logic [CNT_W-1:0] corr_cnt_o
`endif
);
    logic load, used, wrong, stall;

    always_comb begin
        load  = memread_i & memtoreg_i;
        used  = (regdst_i == regsrc1_i) | (regdst_i == regsrc2_i);
        wrong = prediction_i ^ ifbranch_i;
        // A misprediction flush wins over the load-use stall.
        stall = load & used & ~wrong;
        stall_LW_o = ~rst_i & stall;
        jr_o       = ~rst_i & isjump_i & ~stall & ~wrong;
        prewrong_o = ~rst_i & wrong;
        precorrc_o = ~rst_i & prediction_i & ifbranch_i;
    end

`ifdef HAZARD_STATS_EN
    hazard_cnt u_stall_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(stall_LW_o), .cnt_o(stall_cnt_o));
    hazard_cnt u_jr_cnt    (.clk_i(clk_i), .rst_i(rst_i), .inc_i(jr_o),       .cnt_o(jr_cnt_o));
    hazard_cnt u_wrong_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(prewrong_o), .cnt_o(wrong_cnt_o));
    hazard_cnt u_corr_cnt  (.clk_i(clk_i), .rst_i(rst_i), .inc_i(precorrc_o), .cnt_o(corr_cnt_o));
`else
    logic unused_clk;
    assign unused_clk = clk_i;
`endif
endmodule

// File: tb/tb_hazard.sv
// tb_hazard: directed and randomized checks of hazard against an in-bench reference model.
module tb_hazard;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       memtoreg = 1'b0, memread = 1'b0, isjump = 1'b0, ifbranch = 1'b0, prediction = 1'b0;
    logic [3:0] regdst = '0, regsrc1 = '0, regsrc2 = '0;
    logic       stall_lw, jr, prewrong, precorrc;
    int         vectors = 0;
    int         miscompares = 0;
    bit         run = 1'b0;
    int         mcnt [4];

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, jr_cnt, wrong_cnt, corr_cnt;
`endif

    hazard dut (
        .clk_i(clk), .rst_i(rst), .memtoreg_i(memtoreg), .memread_i(memread),
        .regdst_i(regdst), .regsrc1_i(regsrc1), .regsrc2_i(regsrc2),
        .isjump_i(isjump), .ifbranch_i(ifbranch), .prediction_i(prediction),
        .stall_LW_o(stall_lw), .jr_o(jr), .prewrong_o(prewrong), .precorrc_o(precorrc)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt_o(stall_cnt), .jr_cnt_o(jr_cnt), .wrong_cnt_o(wrong_cnt), .corr_cnt_o(corr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected {stall, jr, wrong, corr} straight from the hazard rules.
    function automatic logic [3:0] model();
        bit w, c, hit, s, j;
        if (rst) return 4'b0000;
        w   = prediction != ifbranch;
        c   = prediction && ifbranch;
        hit = memread && memtoreg && (regdst == regsrc1 || regdst == regsrc2);
        s   = hit && !w;
        j   = isjump && !s && !w;
        return {s, j, w, c};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference event counters, saturating at 65535.
    always @(posedge clk) begin
        logic [3:0] e;
        e = model();
        for (int i = 0; i < 4; i++)
            if (rst) mcnt[i] = 0;
            else if (e[3-i] && mcnt[i] < 65535) mcnt[i] = mcnt[i] + 1;
    end

    always @(negedge clk) begin
        if (run) begin
            chk("outputs", {12'd0, stall_lw, jr, prewrong, precorrc}, {12'd0, model()});
`ifdef HAZARD_STATS_EN
            chk("stall_cnt", stall_cnt, mcnt[0][15:0]);
            chk("jr_cnt",    jr_cnt,    mcnt[1][15:0]);
            chk("wrong_cnt", wrong_cnt, mcnt[2][15:0]);
            chk("corr_cnt",  corr_cnt,  mcnt[3][15:0]);
`endif
        end
    end

    task automatic drive(input logic r, input logic mtr, input logic mr, input logic [3:0] d,
                         input logic [3:0] s1, input logic [3:0] s2, input logic j,
                         input logic br, input logic pr);
        @(posedge clk);
        #1;
        rst = r; memtoreg = mtr; memread = mr; regdst = d; regsrc1 = s1; regsrc2 = s2;
        isjump = j; ifbranch = br; prediction = pr;
        #1;
    endtask

    initial begin
        // Reset with the stalling load-use inputs applied: everything gated to 0.
        drive(1, 1, 1, 3, 3, 5, 0, 1, 1);
        run = 1'b1;
        chk("rst_stall", {15'd0, stall_lw}, 16'd0);
        chk("rst_jr", {15'd0, jr}, 16'd0);
        chk("rst_wrong", {15'd0, prewrong}, 16'd0);
        chk("rst_corr", {15'd0, precorrc}, 16'd0);
        // Load-use under a misprediction: flush wins.
        drive(0, 1, 1, 3, 3, 5, 0, 0, 1);
        chk("lu_wrong", {15'd0, prewrong}, 16'd1);
        chk("lu_nostall", {15'd0, stall_lw}, 16'd0);
        drive(0, 1, 1, 3, 3, 5, 0, 1, 1);
        chk("lu_stall", {15'd0, stall_lw}, 16'd1);
        chk("lu_nowrong", {15'd0, prewrong}, 16'd0);
        chk("lu_corr", {15'd0, precorrc}, 16'd1);
        // JR waits for its loaded operand.
        drive(0, 1, 1, 9, 9, 0, 1, 0, 0);
        chk("jr_stall", {15'd0, stall_lw}, 16'd1);
        chk("jr_held", {15'd0, jr}, 16'd0);
        drive(0, 1, 1, 4, 9, 0, 1, 0, 0);
        chk("jr_go", {15'd0, jr}, 16'd1);
        chk("jr_nostall", {15'd0, stall_lw}, 16'd0);
        // No load, register match on src2.
        drive(0, 1, 0, 13, 0, 13, 0, 0, 0);
        chk("noload", {15'd0, stall_lw}, 16'd0);
        // All three indices equal behaves like a single match.
        drive(0, 1, 1, 7, 7, 7, 0, 0, 0);
        chk("tri_match", {15'd0, stall_lw}, 16'd1);
        // Correct not-taken prediction raises nothing.
        drive(0, 0, 0, 1, 2, 3, 0, 0, 0);
        chk("nt_quiet", {12'd0, stall_lw, jr, prewrong, precorrc}, 16'd0);
        // Randomized traffic with small register ranges and occasional mid-run reset.
        for (int n = 0; n < 3000; n++)
            drive($urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom));
`ifdef HAZARD_STATS_EN
        // Hold a load-use stall long enough to saturate its counter.
        drive(1, 1, 1, 6, 6, 2, 0, 0, 0);
        drive(0, 1, 1, 6, 6, 2, 0, 0, 0);
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall", stall_cnt, 16'hFFFF);
        chk("sat_jr", jr_cnt, 16'h0000);
        chk("sat_wrong", wrong_cnt, 16'h0000);
        chk("sat_corr", corr_cnt, 16'h0000);
        // Mid-operation reset clears the counters on the edge.
        drive(1, 1, 1, 6, 6, 2, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_cnt", stall_cnt, 16'h0000);
`endif
        repeat (2) @(posedge clk);
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
